bus_master_ctrl: RTL and testbench
==================================

Name: bus_master_ctrl

Overview:
- Initiator side of the shared CPLD peripheral bus: 4-bit `address`, `enable` strobe, 8-bit bidirectional `bus`.
- Converts single-cycle host requests into correctly sequenced bus cycles, with address setup, strobe and release phases.
- Read: `enable`=1, the selected peripheral drives `bus` (e.g. switches at 4'hD). Write: `enable`=0, master drives `bus`, the selected peripheral latches it (e.g. LED at 4'hC).
- Sits between host logic (safe/XOR controller) and the address decoder plus peripherals.

Parameters:
- SETUP_CYCLES, 2, cycles `address` is held stable before the access phase (min 1).
- ACCESS_CYCLES, 2, cycles of the access phase (min 1).
- IDLE_ADDR, 4'h0, address driven when idle; must decode to no peripheral.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  host request; sampled only in IDLE.
- rw  input  1  1=read, 0=write; sampled with req.
- addr_in  input  4  target address; sampled with req.
- wdata  input  8  write data; sampled with req.
- rdata  output  8  read data; valid from the `done` cycle, held until the next read completes.
- busy  output  1  high from SETUP through RELEASE.
- done  output  1  one-cycle completion pulse.
- address  output  4  bus address.
- enable  output  1  bus strobe: 1=read/inactive, 0=write.
- bus  inout  8  shared data bus.

Behaviour:
- All outputs are registered. The `bus` output-enable is a register; `bus` is 8'hz whenever not driving.
- Reset (async, immediate, including mid-transaction):
  - State=IDLE, `address`=IDLE_ADDR, `enable`=1, `bus`=Z.
  - `rdata`=8'h00, `busy`=0, `done`=0, counters=0.
- FSM states: IDLE, SETUP, ACCESS, RELEASE.
- IDLE:
  - `address`=IDLE_ADDR, `enable`=1, `bus`=Z.
  - `req`=1 latches `rw`, `addr_in` and `wdata`, then moves to SETUP. Otherwise stay.
- SETUP (SETUP_CYCLES cycles):
  - `address`=latched addr, `enable`=1, `bus`=Z.
  - Exit to ACCESS when the counter reaches SETUP_CYCLES-1.
- ACCESS (ACCESS_CYCLES cycles):
  - Write: `enable`=0, `bus`=latched wdata.
  - Read: `enable`=1, `bus`=Z. `bus` is captured into `rdata` on the clock edge ending the last ACCESS cycle.
  - Exit to RELEASE.
- RELEASE (1 cycle):
  - `enable`=1, `bus`=Z, `address` still held. This guarantees no drive overlap with a read peripheral and no spurious LED latch.
  - Next: IDLE with `done`=1.
- Latency: `req` sampled at edge E0 → `done` high in cycle E0+SETUP_CYCLES+ACCESS_CYCLES+2 (defaults: 6 cycles). `busy` falls in the same cycle `done` rises.
- Back-to-back: `req` high in the `done` cycle is accepted. The next SETUP starts the following cycle; `address` returns to IDLE_ADDR for exactly that one `done` cycle.
- `req` while `busy`=1 is ignored (not queued). `addr_in`/`wdata`/`rw` changes while busy have no effect.
- Invariant: `enable`=0 is never asserted in the same cycle `bus` is undriven, nor with `address`=IDLE_ADDR.
- Invariant: `bus` is never driven while `enable`=1.
- Counters are sized by $clog2 of the parameter and clear on every state change.
- No address checking: any 4-bit address is issued as given.

Test Plan:
- Write, defaults: `req`=1, `rw`=0, `addr_in`=4'hC, `wdata`=8'hA5 at edge 0 →
  - cycles 1-2: `address`=C, `enable`=1, `bus`=Z.
  - cycles 3-4: `enable`=0, `bus`=A5.
  - cycle 5: `enable`=1, `bus`=Z, `address`=C.
  - cycle 6: `done`=1, `busy`=0, `address`=0.
- Read: bench drives `bus`=8'h3C when `address`=D & `enable`=1; `req`, `rw`=1, `addr_in`=4'hD →
  - `enable` never low, master never drives `bus`.
  - `rdata`=8'h3C at the `done` cycle (cycle 6), held thereafter.
- Back-to-back: write C/8'h5A then a read issued in the `done` cycle → second SETUP starts next cycle; `address` is 0 for exactly one cycle between transactions.
- Ignored request: pulse `req` with `addr_in`=4'h9 during the first write's ACCESS → no extra transaction; only one `done` pulse.
- Async reset asserted mid-ACCESS of a write → same cycle, without waiting for a clock edge: `bus`=Z, `enable`=1, `address`=0, `busy`=0, `rdata`=00. After release, a new read completes normally.
- SETUP_CYCLES=1, ACCESS_CYCLES=3 build → write `done` at cycle 6 with exactly 3 cycles of `enable`=0.

Source files
------------

// File: rtl/bus_master_ctrl.sv
// Initiator for the shared CPLD peripheral bus: turns one-cycle host requests
// into SETUP / ACCESS / RELEASE bus cycles with registered outputs and a registered bus drive.
module bus_master_ctrl #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [3:0]  IDLE_ADDR     = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rw,
    input  logic [3:0] addr_in,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic [3:0] address,
    output logic       enable,
    inout  logic [7:0] bus
);

    localparam int unsigned SCW = (SETUP_CYCLES  > 1) ? $clog2(SETUP_CYCLES)  : 1;
    localparam int unsigned ACW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [SCW-1:0] SETUP_LAST  = SCW'(SETUP_CYCLES - 1);
    localparam logic [ACW-1:0] ACCESS_LAST = ACW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [SCW-1:0] setup_cnt_q, setup_cnt_d;
    logic [ACW-1:0] access_cnt_q, access_cnt_d;
    logic           rw_q, rw_d;
    logic [3:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [3:0]     address_q, address_d;
    logic           enable_q, enable_d;
    logic           bus_oe_q, bus_oe_d;
    logic [7:0]     bus_data_q, bus_data_d;

    always_comb begin
        state_d      = state_q;
        setup_cnt_d  = '0;
        access_cnt_d = '0;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    addr_d  = addr_in;
                    wdata_d = wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    state_d = S_ACCESS;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            S_ACCESS: begin
                if (access_cnt_q == ACCESS_LAST) begin
                    state_d = S_RELEASE;
                    if (rw_q) begin
                        rdata_d = bus;
                    end
                end else begin
                    access_cnt_d = access_cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output registers are loaded from the decode of the next state so that
        // address, strobe and drive change on the same edge as the state itself.
        address_d  = (state_d == S_IDLE) ? IDLE_ADDR : addr_d;
        bus_oe_d   = (state_d == S_ACCESS) && !rw_d;
        enable_d   = !bus_oe_d;
        bus_data_d = bus_oe_d ? wdata_d : '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_RELEASE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            setup_cnt_q  <= '0;
            access_cnt_q <= '0;
            rw_q         <= 1'b0;
            addr_q       <= IDLE_ADDR;
            wdata_q      <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            address_q    <= IDLE_ADDR;
            enable_q     <= 1'b1;
            bus_oe_q     <= 1'b0;
            bus_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            setup_cnt_q  <= setup_cnt_d;
            access_cnt_q <= access_cnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            address_q    <= address_d;
            enable_q     <= enable_d;
            bus_oe_q     <= bus_oe_d;
            bus_data_q   <= bus_data_d;
        end
    end

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign address = address_q;
    assign enable  = enable_q;
    assign bus     = bus_oe_q ? bus_data_q : 8'hzz;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: default build with a read peripheral at 4'hD,
// plus a SETUP_CYCLES=1 / ACCESS_CYCLES=3 build for the write timing.
module tb_bus_master_ctrl;

    logic       clk;
    logic       reset;

    logic       req0, rw0;
    logic [3:0] addr_in0;
    logic [7:0] wdata0;
    logic [7:0] rdata0;
    logic       busy0, done0, enable0;
    logic [3:0] address0;
    wire  [7:0] bus0;
    logic [7:0] periph_val;

    logic       req1, rw1;
    logic [3:0] addr_in1;
    logic [7:0] wdata1;
    logic [7:0] rdata1;
    logic       busy1, done1, enable1;
    logic [3:0] address1;
    wire  [7:0] bus1;

    int unsigned passed;
    int unsigned total;
    int unsigned en_low_cnt;

    bus_master_ctrl dut0 (
        .clk     (clk),
        .reset   (reset),
        .req     (req0),
        .rw      (rw0),
        .addr_in (addr_in0),
        .wdata   (wdata0),
        .rdata   (rdata0),
        .busy    (busy0),
        .done    (done0),
        .address (address0),
        .enable  (enable0),
        .bus     (bus0)
    );

    bus_master_ctrl #(
        .SETUP_CYCLES  (1),
        .ACCESS_CYCLES (3),
        .IDLE_ADDR     (4'h0)
    ) dut1 (
        .clk     (clk),
        .reset   (reset),
        .req     (req1),
        .rw      (rw1),
        .addr_in (addr_in1),
        .wdata   (wdata1),
        .rdata   (rdata1),
        .busy    (busy1),
        .done    (done1),
        .address (address1),
        .enable  (enable1),
        .bus     (bus1)
    );

    // Switch peripheral at 4'hD: drives the bus whenever it is selected with enable high.
    assign bus0 = (address0 == 4'hD && enable0) ? periph_val : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic exp0(input string tag, input logic [3:0] a, input logic en, input logic oe,
                        input logic [7:0] d, input logic bsy, input logic dn);
        chk({tag, ".address"}, {28'd0, address0}, {28'd0, a});
        chk({tag, ".enable"},  {31'd0, enable0},  {31'd0, en});
        chk({tag, ".drive"},   {31'd0, dut0.bus_oe_q}, {31'd0, oe});
        chk({tag, ".busy"},    {31'd0, busy0},    {31'd0, bsy});
        chk({tag, ".done"},    {31'd0, done0},    {31'd0, dn});
        if (oe) chk({tag, ".bus"}, {24'd0, bus0}, {24'd0, d});
    endtask

    task automatic start0(input logic r, input logic [3:0] a, input logic [7:0] d);
        req0 = 1'b1; rw0 = r; addr_in0 = a; wdata0 = d;
        tick();
        req0 = 1'b0;
    endtask

    initial begin
        passed = 0; total = 0; en_low_cnt = 0;
        reset = 1'b1;
        req0 = 1'b0; rw0 = 1'b0; addr_in0 = 4'h0; wdata0 = 8'h00; periph_val = 8'h3C;
        req1 = 1'b0; rw1 = 1'b0; addr_in1 = 4'h0; wdata1 = 8'h00;
        tick(); tick();
        exp0("reset", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset.rdata", {24'd0, rdata0}, 32'h00);
        reset = 1'b0;
        tick();

        // Write C/A5, with an ignored request pulse during ACCESS
        start0(1'b0, 4'hC, 8'hA5);
        exp0("wr.c1", 4'hC, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("wr.c2", 4'hC, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("wr.c3", 4'hC, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        req0 = 1'b1; rw0 = 1'b1; addr_in0 = 4'h9; wdata0 = 8'hFF;
        tick(); req0 = 1'b0;
        exp0("wr.c4", 4'hC, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        tick(); exp0("wr.c5", 4'hC, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("wr.c6", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick(); exp0("wr.c7", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(); exp0("wr.c8", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Read D, peripheral returns 3C
        start0(1'b1, 4'hD, 8'h00);
        exp0("rd.c1", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("rd.c2", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("rd.c3", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("rd.c4", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("rd.c5", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); exp0("rd.c6", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rd.c6.rdata", {24'd0, rdata0}, 32'h3C);
        tick(); tick();
        chk("rd.c8.rdata", {24'd0, rdata0}, 32'h3C);

        // Back-to-back: write C/5A, then read D issued in the done cycle
        periph_val = 8'h69;
        start0(1'b0, 4'hC, 8'h5A);
        tick(); tick();
        exp0("b2b.c3", 4'hC, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        tick(); tick();
        exp0("b2b.c5", 4'hC, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        exp0("b2b.c6", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        start0(1'b1, 4'hD, 8'h00);
        exp0("b2b.c7", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        exp0("b2b.c11", 4'hD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        exp0("b2b.c12", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("b2b.c12.rdata", {24'd0, rdata0}, 32'h69);

        // Asynchronous reset in the middle of a write ACCESS
        tick();
        start0(1'b0, 4'hC, 8'hA5);
        tick(); tick();
        exp0("rst.pre", 4'hC, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        exp0("rst.async", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst.async.rdata", {24'd0, rdata0}, 32'h00);
        tick();
        reset = 1'b0;
        tick();
        periph_val = 8'h3C;
        start0(1'b1, 4'hD, 8'h00);
        tick(); tick(); tick(); tick();
        tick(); exp0("rst.rd.c6", 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst.rd.c6.rdata", {24'd0, rdata0}, 32'h3C);

        // SETUP_CYCLES=1, ACCESS_CYCLES=3 build: write C/A5
        req1 = 1'b1; rw1 = 1'b0; addr_in1 = 4'hC; wdata1 = 8'hA5;
        tick();
        req1 = 1'b0;
        chk("p13.c1.address", {28'd0, address1}, 32'hC);
        chk("p13.c1.enable",  {31'd0, enable1},  32'd1);
        for (int c = 1; c <= 7; c++) begin
            if (!enable1) en_low_cnt++;
            if (c == 2) chk("p13.c2.bus", {24'd0, bus1}, 32'hA5);
            if (c == 5) chk("p13.c5.done", {31'd0, done1}, 32'd0);
            if (c == 6) begin
                chk("p13.c6.done", {31'd0, done1}, 32'd1);
                chk("p13.c6.busy", {31'd0, busy1}, 32'd0);
            end
            tick();
        end
        chk("p13.enable_low_cycles", en_low_cnt, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
